// File: rtl/digito_atuadores_mux.sv
// Multi-channel actuator status display: per-channel latched active flags,
// shared six-step segment animation, multiplexed digit scan and a blink LED.
module digito_atuadores_mux #(
  parameter int N_CANAIS    = 4,
  parameter int MODO_TOGGLE = 0,
  parameter int DIV_ANIM    = 4,
  parameter int DIV_PISCA   = 8,
  parameter int DIV_VARRE   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          estado,
  input  logic                sinal,
  input  logic [N_CANAIS-1:0] botao,
  output logic [6:0]          segmentos,
  output logic [N_CANAIS-1:0] anodo,
  output logic [N_CANAIS-1:0] ativo,
  output logic                pisca
);
  localparam int IW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
  localparam int AW = $clog2(DIV_ANIM + 1);
  localparam int PW = $clog2(DIV_PISCA + 1);
  localparam int VW = $clog2(DIV_VARRE + 1);
  localparam logic [6:0] DIGITO_ZERO = 7'b0111111;

  logic [N_CANAIS-1:0] r_sync1, r_sync2, r_sync_d, r_ativo, r_anodo;
  logic [AW-1:0]       r_pre_anim;
  logic [PW-1:0]       r_pre_pisca;
  logic [VW-1:0]       r_pre_varre;
  logic [2:0]          r_passo;
  logic [IW-1:0]       r_indice;
  logic                r_fase, r_pisca;
  logic [6:0]          r_segmentos;

  logic [N_CANAIS-1:0] w_borda, w_ativo_nxt, w_onehot;
  logic                w_fim_anim, w_fim_pisca, w_fim_varre, w_canal_ativo;
  logic [6:0]          w_padrao;

  assign w_fim_anim  = (r_pre_anim  == AW'(DIV_ANIM - 1));
  assign w_fim_pisca = (r_pre_pisca == PW'(DIV_PISCA - 1));
  assign w_fim_varre = (r_pre_varre == VW'(DIV_VARRE - 1));

  always_comb begin
    w_borda     = r_sync2 & ~r_sync_d;
    w_ativo_nxt = r_ativo;
    if (estado == 2'b11) begin
      if (!sinal) w_ativo_nxt = '0;
    end else if (estado == 2'b01) begin
      if (MODO_TOGGLE != 0) w_ativo_nxt = r_ativo ^ w_borda;
      else                  w_ativo_nxt = r_ativo | w_borda;
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < N_CANAIS; i++) begin
      w_onehot[i] = (r_indice == IW'(i));
    end
    w_canal_ativo = |(r_ativo & w_onehot);
    w_padrao      = w_canal_ativo ? (7'b1000000 | (7'd1 << r_passo)) : DIGITO_ZERO;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_d    <= '0;
      r_ativo     <= '0;
      r_pre_anim  <= '0;
      r_pre_pisca <= '0;
      r_pre_varre <= '0;
      r_passo     <= '0;
      r_indice    <= '0;
      r_fase      <= 1'b0;
      r_segmentos <= '0;
      r_anodo     <= '0;
      r_pisca     <= 1'b0;
    end else begin
      r_sync1  <= botao;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_ativo  <= w_ativo_nxt;

      r_pre_anim <= w_fim_anim ? '0 : r_pre_anim + AW'(1);
      if (w_fim_anim) r_passo <= (r_passo == 3'd5) ? 3'd0 : r_passo + 3'd1;

      r_pre_pisca <= w_fim_pisca ? '0 : r_pre_pisca + PW'(1);
      if (w_fim_pisca) r_fase <= ~r_fase;

      r_pre_varre <= w_fim_varre ? '0 : r_pre_varre + VW'(1);
      if (w_fim_varre) r_indice <= (r_indice == IW'(N_CANAIS - 1)) ? '0 : r_indice + IW'(1);

      // anodo and segmentos sample the same indice so digit and pattern switch together
      r_anodo     <= w_onehot;
      r_segmentos <= w_padrao;
      // a held button (delayed sync stage) masks its channel's blink contribution
      r_pisca     <= r_fase & |(r_ativo & ~r_sync_d);
    end
  end

  assign segmentos = r_segmentos;
  assign anodo     = r_anodo;
  assign ativo     = r_ativo;
  assign pisca     = r_pisca;
endmodule

// File: tb/tb_digito_atuadores_mux.sv
// Bench for digito_atuadores_mux: two instances (set mode, toggle mode) checked
// every cycle against a cycle-count based reference, plus table and hand sequences.
module tb_digito_atuadores_mux;
  localparam int A0 = 4, B0 = 8, V0 = 16;
  localparam int A1 = 1, B1 = 3, V1 = 5;

  logic       clock, reset_n, sinal;
  logic [1:0] estado;
  logic [3:0] botao;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1, at0, at1;
  logic       pis0, pis1;

  int n_vec = 0;
  int n_err = 0;
  bit run_chk = 0;

  digito_atuadores_mux #(.N_CANAIS(4), .MODO_TOGGLE(0), .DIV_ANIM(A0), .DIV_PISCA(B0), .DIV_VARRE(V0)) dut (
    .clock(clock), .reset_n(reset_n), .estado(estado), .sinal(sinal), .botao(botao),
    .segmentos(seg0), .anodo(an0), .ativo(at0), .pisca(pis0));

  digito_atuadores_mux #(.N_CANAIS(4), .MODO_TOGGLE(1), .DIV_ANIM(A1), .DIV_PISCA(B1), .DIV_VARRE(V1)) dut_t (
    .clock(clock), .reset_n(reset_n), .estado(estado), .sinal(sinal), .botao(botao),
    .segmentos(seg1), .anodo(an1), .ativo(at1), .pisca(pis1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: t = edges since reset release; b0/b1/b2 = botao seen at the last three edges
  typedef struct packed {
    int unsigned t;
    logic [3:0]  ativo, b0, b1, b2;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pis;
  } mdl_t;

  mdl_t m0 = '0;
  mdl_t m1 = '0;

  function automatic logic [6:0] pat(int p);
    return 7'b1000000 | (7'd1 << p);
  endfunction

  function automatic mdl_t mstep(mdl_t s, int tog, int da, int dp, int dv,
                                 logic rn, logic [1:0] est, logic sin, logic [3:0] b);
    mdl_t n;
    int idx, ps, fs;
    logic [3:0] pressed;
    n = s;
    if (!rn) begin
      n = '0;
      return n;
    end
    idx = int'((s.t / dv) % 4);
    ps  = int'((s.t / da) % 6);
    fs  = int'((s.t / dp) % 2);
    n.an  = 4'b0001 << idx;
    n.seg = s.ativo[idx] ? pat(ps) : 7'b0111111;
    n.pis = (fs == 1) && ((s.ativo & ~s.b2) != 4'b0000);
    pressed = s.b1 & ~s.b2;
    if (est == 2'b11) begin
      if (!sin) n.ativo = 4'b0000;
    end else if (est == 2'b01) begin
      n.ativo = (tog != 0) ? (s.ativo ^ pressed) : (s.ativo | pressed);
    end
    n.b2 = s.b1;
    n.b1 = s.b0;
    n.b0 = b;
    n.t  = s.t + 1;
    return n;
  endfunction

  always @(posedge clock) begin
    m0 <= mstep(m0, 0, A0, B0, V0, reset_n, estado, sinal, botao);
    m1 <= mstep(m1, 1, A1, B1, V1, reset_n, estado, sinal, botao);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (run_chk) begin
      chk("seg_i0", 32'(seg0), 32'(m0.seg));
      chk("an_i0", 32'(an0), 32'(m0.an));
      chk("ativo_i0", 32'(at0), 32'(m0.ativo));
      chk("pisca_i0", 32'(pis0), 32'(m0.pis));
      chk("seg_i1", 32'(seg1), 32'(m1.seg));
      chk("an_i1", 32'(an1), 32'(m1.an));
      chk("ativo_i1", 32'(at1), 32'(m1.ativo));
      chk("pisca_i1", 32'(pis1), 32'(m1.pis));
    end
  end

  typedef struct {
    logic [1:0] est;
    logic       sin;
    logic [3:0] bt;
    int         cyc;
    logic [3:0] ex0, ex1;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int p, prev_p, run, cnt;
    bit prev_in, run_ok, found;
    logic [6:0] prev_seg;
    logic prev_pis;

    tbl[0]  = '{2'b01, 1'b0, 4'b0100,  4, 4'b0100, 4'b0100};
    tbl[1]  = '{2'b01, 1'b0, 4'b0000,  4, 4'b0100, 4'b0100};
    tbl[2]  = '{2'b01, 1'b0, 4'b0001,  4, 4'b0101, 4'b0101};
    tbl[3]  = '{2'b01, 1'b0, 4'b0000,  4, 4'b0101, 4'b0101};
    tbl[4]  = '{2'b11, 1'b1, 4'b0000, 20, 4'b0101, 4'b0101};
    tbl[5]  = '{2'b11, 1'b1, 4'b1010,  4, 4'b0101, 4'b0101};
    tbl[6]  = '{2'b11, 1'b1, 4'b0000,  4, 4'b0101, 4'b0101};
    tbl[7]  = '{2'b11, 1'b0, 4'b0000,  1, 4'b0000, 4'b0000};
    tbl[8]  = '{2'b00, 1'b0, 4'b1111,  4, 4'b0000, 4'b0000};
    tbl[9]  = '{2'b00, 1'b0, 4'b0000,  4, 4'b0000, 4'b0000};
    tbl[10] = '{2'b10, 1'b0, 4'b1111,  4, 4'b0000, 4'b0000};
    tbl[11] = '{2'b10, 1'b0, 4'b0000,  4, 4'b0000, 4'b0000};
    tbl[12] = '{2'b01, 1'b0, 4'b1010,  4, 4'b1010, 4'b1010};
    tbl[13] = '{2'b01, 1'b0, 4'b0000,  4, 4'b1010, 4'b1010};
    tbl[14] = '{2'b01, 1'b0, 4'b0001,  4, 4'b1011, 4'b1011};
    tbl[15] = '{2'b01, 1'b0, 4'b0000,  4, 4'b1011, 4'b1011};
    tbl[16] = '{2'b01, 1'b0, 4'b0001,  4, 4'b1011, 4'b1010};
    tbl[17] = '{2'b01, 1'b0, 4'b0000,  4, 4'b1011, 4'b1010};

    reset_n = 1'b0;
    estado  = 2'b00;
    sinal   = 1'b0;
    botao   = 4'b0000;
    repeat (3) @(negedge clock);
    run_chk = 1;
    chk("rst_seg", 32'(seg0), 32'h0);
    chk("rst_an", 32'(an0), 32'h0);
    chk("rst_ativo", 32'(at0), 32'h0);
    chk("rst_pisca", 32'(pis0), 32'h0);

    // idle scan walk
    reset_n = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      @(negedge clock);
      if (e == 1 || (e % 16) == 0 || (e % 16) == 1) begin
        chk("walk_an", 32'(an0), 32'(4'b0001 << (((e - 1) / 16) % 4)));
        chk("walk_seg", 32'(seg0), 32'(7'b0111111));
        chk("walk_pisca", 32'(pis0), 32'h0);
      end
    end

    // flag update table
    for (int v = 0; v < 18; v++) begin
      estado = tbl[v].est;
      sinal  = tbl[v].sin;
      botao  = tbl[v].bt;
      repeat (tbl[v].cyc) @(negedge clock);
      chk($sformatf("tbl%0d_ativo_i0", v), 32'(at0), 32'(tbl[v].ex0));
      chk($sformatf("tbl%0d_ativo_i1", v), 32'(at1), 32'(tbl[v].ex1));
    end

    // only channel 2 active, then watch its animation
    estado = 2'b11; sinal = 1'b0; botao = 4'b0000;
    @(negedge clock);
    estado = 2'b01;
    botao  = 4'b0100;
    repeat (4) @(negedge clock);
    botao = 4'b0000;
    repeat (2) @(negedge clock);
    estado = 2'b00;
    chk("anim_setup_i0", 32'(at0), 32'(4'b0100));
    chk("anim_setup_i1", 32'(at1), 32'(4'b0100));
    prev_in = 0; prev_p = 0; prev_seg = '0; run = 0; run_ok = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clock);
      if (an0 == 4'b0100) begin
        p = -1;
        for (int k = 0; k < 6; k++) if (seg0 == pat(k)) p = k;
        chk("anim_valid", 32'(p >= 0), 32'h1);
        if (prev_in && seg0 != prev_seg) begin
          chk("anim_next", 32'(seg0), 32'(pat((prev_p + 1) % 6)));
          if (run_ok) chk("anim_dwell", 32'(run), 32'(A0));
          run = 1;
          run_ok = 1;
        end else if (prev_in) begin
          run++;
        end else begin
          run = 1;
          run_ok = 0;
        end
        prev_p = p;
        prev_seg = seg0;
        prev_in = 1;
      end else begin
        chk("anim_idle_digit", 32'(seg0), 32'(7'b0111111));
        prev_in = 0;
      end
    end

    // blink period, then masking while the active channel's button is held
    prev_pis = pis0;
    cnt = 0;
    while (pis0 == prev_pis && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    chk("blink_start", 32'(pis0 != prev_pis), 32'h1);
    for (int h = 0; h < 2; h++) begin
      prev_pis = pis0;
      cnt = 0;
      do begin
        @(negedge clock);
        cnt++;
      end while (pis0 == prev_pis && cnt < 40);
      chk("blink_half", 32'(cnt), 32'(B0));
    end
    botao = 4'b0100;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      if (j >= 4) chk("blink_held", 32'(pis0), 32'h0);
    end
    botao = 4'b0000;
    repeat (4) @(negedge clock);

    // reset while passo=4 and indice=3
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (((m0.t / A0) % 6) == 4 && ((m0.t / V0) % 4) == 3) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    chk("midop_reach", 32'(found), 32'h1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midop_seg", 32'(seg0), 32'h0);
    chk("midop_an", 32'(an0), 32'h0);
    chk("midop_ativo", 32'(at0), 32'h0);
    chk("midop_pisca", 32'(pis0), 32'h0);
    chk("midop_an_i1", 32'(an1), 32'h0);
    reset_n = 1'b1;
    estado  = 2'b01;
    botao   = 4'b0001;
    @(negedge clock);
    chk("restart_an", 32'(an0), 32'(4'b0001));
    repeat (2) @(negedge clock);
    chk("restart_ativo", 32'(at0), 32'(4'b0001));
    @(negedge clock);
    chk("restart_step0", 32'(seg0), 32'(7'b1000001));
    @(negedge clock);
    chk("restart_step1", 32'(seg0), 32'(7'b1000010));
    botao = 4'b0000;

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      int r, b;
      if ((i % 8) == 0) begin
        r = int'($urandom_range(0, 7));
        estado = (r < 4) ? 2'b01 : (r == 4) ? 2'b00 : (r == 5) ? 2'b10 : 2'b11;
        sinal  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, 3));
        botao[b] = ~botao[b];
      end
      reset_n = ($urandom_range(0, 499) != 0);
      @(negedge clock);
    end
    reset_n = 1'b1;
    @(negedge clock);
    run_chk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
